mtimer: RTL and testbench

//  Parametrised 64-bit machine timer on the valid/ready peripheral bus. Free-running count with

---
 rtl/mtimer_pkg.sv | 34 +++
 rtl/mtimer_prescaler.sv | 30 +++
 rtl/mtimer.sv | 136 +++++++++++++
 tb/tb_mtimer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mtimer_pkg.sv
// Shared register map and helpers for the 64-bit machine timer.
// Offsets are word indices, i.e. addr[7:2].
package mtimer_pkg;

  localparam int N_CMP_MAX = 8;

  localparam logic [5:0] OFF_MTIME_LO = 6'h00;
  localparam logic [5:0] OFF_MTIME_HI = 6'h01;
  localparam logic [5:0] OFF_CTRL     = 6'h02;
  localparam logic [5:0] OFF_PRESCALE = 6'h03;
  localparam logic [5:0] OFF_IRQ_EN   = 6'h04;
  localparam logic [5:0] OFF_IRQ_RAW  = 6'h05;

  localparam int CMP_BASE   = 8;
  localparam int CMP_STRIDE = 2;

  localparam int CTRL_EN = 0;

  function automatic logic [5:0] cmp_idx(input int ch, input logic hi);
    return 6'(CMP_BASE + CMP_STRIDE * ch + (hi ? 1 : 0));
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for the machine timer: emits one tick every PRESCALE+1 enabled cycles.
// The counter is not re-ranged on a reload, so a smaller reload lets it run to wrap.
module mtimer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_clear,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_pre_cnt;

  assign o_tick = i_en && (r_pre_cnt == i_prescale);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pre_cnt <= '0;
    end else if (i_clear) begin
      r_pre_cnt <= '0;
    end else if (o_tick) begin
      r_pre_cnt <= '0;
    end else if (i_en) begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mtimer.sv
// 64-bit machine timer on the valid/ready MMIO bus: prescaled free-running count,
// N_CMP compare channels with level irqs, and a high-word snapshot for coherent reads.
module mtimer
  import mtimer_pkg::*;
#(
  parameter int N_CMP      = 2,
  parameter int PRESCALE_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_addr,
  output logic [31:0]      o_rdata,
  input  logic [31:0]      i_wdata,
  input  logic [3:0]       i_wstrb,
  output logic [N_CMP-1:0] o_irq
);

  logic [63:0]           r_mtime;
  logic [31:0]           r_snap_hi;
  logic                  r_en;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [N_CMP-1:0]      r_irq_en;
  logic [N_CMP-1:0]      r_irq;
  logic [63:0]           r_cmp [N_CMP];
  logic                  r_ready;
  logic [31:0]           r_rdata;

  logic [5:0]       w_idx;
  logic             w_capture;
  logic             w_wr;
  logic             w_rd_cap;
  logic             w_wr_mtime_lo;
  logic             w_wr_mtime_hi;
  logic             w_mtime_clear;
  logic             w_tick;
  logic [N_CMP-1:0] w_raw;
  logic [31:0]      w_rd_val;
  logic             w_unused_addr;

  assign w_idx         = i_addr[7:2];
  assign w_unused_addr = ^{i_addr[31:8], i_addr[1:0]};

  // Response is captured on the first valid cycle, the access commits one cycle later.
  assign w_capture     = i_valid && !r_ready;
  assign w_wr          = i_valid && r_ready && (|i_wstrb);
  assign w_rd_cap      = w_capture && (i_wstrb == 4'b0000);
  assign w_wr_mtime_lo = w_wr && (w_idx == OFF_MTIME_LO);
  assign w_wr_mtime_hi = w_wr && (w_idx == OFF_MTIME_HI);
  assign w_mtime_clear = w_wr_mtime_lo || w_wr_mtime_hi;

  mtimer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk        (clk),
    .resetn     (resetn),
    .i_en       (r_en),
    .i_prescale (r_prescale),
    .i_clear    (w_mtime_clear),
    .o_tick     (w_tick)
  );

  for (genvar gi = 0; gi < N_CMP; gi++) begin : g_cmp
    assign w_raw[gi] = (r_mtime >= r_cmp[gi]);
  end

  always_comb begin
    w_rd_val = '0;
    case (w_idx)
      OFF_MTIME_LO: w_rd_val = r_mtime[31:0];
      OFF_MTIME_HI: w_rd_val = r_snap_hi;
      OFF_CTRL:     w_rd_val = 32'(r_en);
      OFF_PRESCALE: w_rd_val = 32'(r_prescale);
      OFF_IRQ_EN:   w_rd_val = 32'(r_irq_en);
      OFF_IRQ_RAW:  w_rd_val = 32'(w_raw);
      default: begin
        for (int i = 0; i < N_CMP; i++) begin
          if (w_idx == cmp_idx(i, 1'b0)) w_rd_val = r_cmp[i][31:0];
          if (w_idx == cmp_idx(i, 1'b1)) w_rd_val = r_cmp[i][63:32];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mtime    <= '0;
      r_snap_hi  <= '0;
      r_en       <= 1'b1;
      r_prescale <= '0;
      r_irq_en   <= '0;
      r_irq      <= '0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      for (int i = 0; i < N_CMP; i++) r_cmp[i] <= '1;
    end else begin
      r_ready <= w_capture;
      if (w_capture) r_rdata <= w_rd_cap ? w_rd_val : '0;

      // Snapshot rides with the LO capture so a following HI read matches it.
      if (w_rd_cap && (w_idx == OFF_MTIME_LO)) r_snap_hi <= r_mtime[63:32];

      // A software write wins over the tick; the untouched half holds its old value.
      if (w_mtime_clear) begin
        if (w_wr_mtime_lo) r_mtime[31:0]  <= byte_merge(r_mtime[31:0], i_wdata, i_wstrb);
        if (w_wr_mtime_hi) r_mtime[63:32] <= byte_merge(r_mtime[63:32], i_wdata, i_wstrb);
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end

      if (w_wr) begin
        case (w_idx)
          OFF_CTRL:     if (i_wstrb[0]) r_en <= i_wdata[CTRL_EN];
          OFF_PRESCALE: r_prescale <= PRESCALE_W'(byte_merge(32'(r_prescale), i_wdata, i_wstrb));
          OFF_IRQ_EN:   r_irq_en   <= N_CMP'(byte_merge(32'(r_irq_en), i_wdata, i_wstrb));
          default: begin
            for (int i = 0; i < N_CMP; i++) begin
              if (w_idx == cmp_idx(i, 1'b0))
                r_cmp[i][31:0]  <= byte_merge(r_cmp[i][31:0], i_wdata, i_wstrb);
              if (w_idx == cmp_idx(i, 1'b1))
                r_cmp[i][63:32] <= byte_merge(r_cmp[i][63:32], i_wdata, i_wstrb);
            end
          end
        endcase
      end

      r_irq <= w_raw & r_irq_en;
    end
  end

  assign o_ready = r_ready;
  assign o_rdata = r_rdata;
  assign o_irq   = r_irq;

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: bus handshake, snapshot coherency, prescaler,
// compare/irq levels, partial MTIME writes and wrap.
module tb_mtimer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        ready;
  logic [31:0] rdata;
  logic [1:0]  irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mtimer #(
    .N_CMP      (2),
    .PRESCALE_W (16)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .i_valid (valid),
    .o_ready (ready),
    .i_addr  (addr),
    .o_rdata (rdata),
    .i_wdata (wdata),
    .i_wstrb (wstrb),
    .o_irq   (irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus access; returns one ns after the commit edge.
  task automatic bus(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r);
    int n;
    valid = 1'b1;
    addr  = {24'h0, a};
    wdata = d;
    wstrb = s;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready && n < 8);
    check("rdy_lat", 64'(n), 64'd1);
    r = rdata;
    @(posedge clk);
    #1;
    check("rdy_pulse", 64'(ready), 64'd0);
    valid = 1'b0;
    wstrb = 4'h0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(a, d, 4'hF, dummy);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] r);
    bus(a, 32'h0, 4'h0, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] v0;
    logic [31:0] v1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_irq",   64'(irq),   64'd0);
    resetn = 1'b1;

    rd(8'h08, v); check("rst_ctrl", 64'(v), 64'd1);
    rd(8'h0C, v); check("rst_presc", 64'(v), 64'd0);
    rd(8'h10, v); check("rst_irqen", 64'(v), 64'd0);
    rd(8'h2C, v); check("rst_cmp1hi", 64'(v), 64'hFFFF_FFFF);
    rd(8'h04, v); check("rst_snap", 64'(v), 64'd0);

    // back-to-back LO reads, PRESCALE=0
    rd(8'h00, v0);
    for (int i = 0; i < 4; i++) begin
      rd(8'h00, v1);
      check("t1_step", 64'(v1 - v0), 64'd2);
      v0 = v1;
    end

    // snapshot coherency across the 32-bit carry
    wr(8'h04, 32'h0);
    wr(8'h00, 32'hFFFF_FFFE);
    rd(8'h00, v); check("t2_lo_a", 64'(v), 64'hFFFF_FFFE);
    rd(8'h04, v); check("t2_hi_a", 64'(v), 64'd0);
    rd(8'h00, v); check("t2_lo_b", 64'(v), 64'd2);
    rd(8'h04, v); check("t2_hi_b", 64'(v), 64'd1);
    wr(8'h00, 32'hFFFF_FFFF);
    rd(8'h00, v); check("t2_lo_c", 64'(v), 64'hFFFF_FFFF);
    rd(8'h04, v); check("t2_hi_c", 64'(v), 64'd1);

    // prescaler 3, freeze and resume phase
    wr(8'h0C, 32'd3);
    wr(8'h04, 32'h0);
    wr(8'h00, 32'h0);
    rd(8'h00, v); check("t3_start", 64'(v), 64'd0);
    idle(15);
    rd(8'h00, v); check("t3_div4", 64'(v), 64'd4);
    wr(8'h08, 32'h0);
    idle(10);
    rd(8'h00, v); check("t3_frz_a", 64'(v), 64'd5);
    rd(8'h00, v); check("t3_frz_b", 64'(v), 64'd5);
    wr(8'h08, 32'h1);
    idle(3);
    rd(8'h00, v); check("t3_phase", 64'(v), 64'd6);

    // compare channel 0
    wr(8'h0C, 32'd0);
    wr(8'h10, 32'h1);
    wr(8'h20, 32'd20);
    wr(8'h24, 32'h0);
    wr(8'h04, 32'h0);
    wr(8'h00, 32'h0);
    idle(2);  check("t4_irq_lo_a", 64'(irq), 64'd0);
    idle(18); check("t4_irq_lo_b", 64'(irq), 64'd0);
    idle(1);  check("t4_irq_rise", 64'(irq), 64'd1);
    rd(8'h14, v); check("t4_raw_a", 64'(v), 64'd1);
    wr(8'h10, 32'h0);
    check("t4_en_hold", 64'(irq), 64'd1);
    idle(1); check("t4_en_off", 64'(irq), 64'd0);
    rd(8'h14, v); check("t4_raw_b", 64'(v), 64'd1);
    wr(8'h10, 32'h1);
    check("t4_en_lag", 64'(irq), 64'd0);
    idle(1); check("t4_en_on", 64'(irq), 64'd1);
    wr(8'h24, 32'hFFFF_FFFF);
    check("t4_cmp_hold", 64'(irq), 64'd1);
    idle(1); check("t4_cmp_drop", 64'(irq), 64'd0);
    rd(8'h14, v); check("t4_raw_c", 64'(v), 64'd0);

    // partial HI write on a tick edge
    wr(8'h0C, 32'd3);
    wr(8'h04, 32'h1122_3344);
    wr(8'h00, 32'h0000_0010);
    idle(2);
    bus(8'h04, 32'hAABB_CCDD, 4'b0011, v);
    rd(8'h00, v); check("t5_lo_hold", 64'(v), 64'h10);
    rd(8'h04, v); check("t5_hi_merge", 64'(v), 64'h1122_CCDD);
    rd(8'h00, v); check("t5_lo_tick", 64'(v), 64'h11);
    idle(1);
    wr(8'h00, 32'h0000_0100);
    idle(3);
    rd(8'h00, v); check("t5_preclr", 64'(v), 64'h100);

    // channel 1 at all-ones, wrap
    wr(8'h0C, 32'd0);
    wr(8'h10, 32'h2);
    wr(8'h28, 32'hFFFF_FFFF);
    wr(8'h04, 32'hFFFF_FFFF);
    wr(8'h00, 32'hFFFF_FFFE);
    check("t6_irq_a", 64'(irq), 64'd0);
    idle(1); check("t6_irq_b", 64'(irq), 64'd0);
    idle(1); check("t6_irq_max", 64'(irq), 64'd2);
    idle(1); check("t6_irq_wrap", 64'(irq), 64'd0);
    rd(8'h00, v); check("t6_lo", 64'(v), 64'd1);
    rd(8'h04, v); check("t6_hi", 64'(v), 64'd0);
    rd(8'h80, v); check("t6_unmap", 64'(v), 64'd0);
    rd(8'h30, v); check("t6_cmp2", 64'(v), 64'd0);
    wr(8'h80, 32'h1234_5678);
    rd(8'h80, v); check("t6_unmap_wr", 64'(v), 64'd0);

    // reset while ready is high
    valid = 1'b1;
    addr  = 32'h0;
    wstrb = 4'h0;
    @(posedge clk);
    #1;
    check("t7_rdy", 64'(ready), 64'd1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("t7_rdy_drop", 64'(ready), 64'd0);
    check("t7_irq", 64'(irq), 64'd0);
    valid  = 1'b0;
    resetn = 1'b1;
    idle(1);
    rd(8'h10, v); check("t7_irqen", 64'(v), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
